rom_stream_reader: RTL and testbench

Sequencer that reads one full pass of a synchronous block ROM (the `rom_ip` core, 32 x 8) and delivers the contents as a valid/ready byte stream. It sits between the ROM and a downstream byte consumer (UART TX, debug capture). It drives the ROM address, compensates the ROM read latency and buffers words in a small FIFO, so back-pressure never drops or duplicates a byte.

---
 rtl/rom_stream_reader_pkg.sv | 21 ++
 rtl/rom_stream_fifo.sv | 52 +++++
 rtl/rom_stream_reader.sv | 136 +++++++++++++
 tb/tb_rom_stream_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_reader_pkg.sv
// Shared types and defaults for the ROM-to-stream sequencer.
// FSM encodings are fixed so that waveform decoders and debug probes stay valid.
package rom_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ROM_LAT    = 1;
    localparam int DEF_FIFO_DEPTH = 4;

    // Occupancy counters need one bit beyond the pointer width to represent "full".
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rom_stream_fifo.sv
// Small synchronous FIFO with show-ahead head (rd_data is the current head entry).
// Pointers carry an extra wrap bit so occupancy is a plain subtraction.
module rom_stream_fifo
    import rom_stream_reader_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr_reg;
    logic [PW:0]      rd_ptr_reg;
    logic             do_wr;
    logic             do_rd;

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

    // A write into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg[PW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg[PW-1:0]];

endmodule

// File: rtl/rom_stream_reader.sv
// Reads one full pass of a synchronous ROM and emits it as a valid/ready byte stream.
// Issue is credit-limited so words already requested always have a FIFO slot waiting.
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ROM_LAT    = DEF_ROM_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int CW = cnt_width(FIFO_DEPTH);
    localparam int EW = DATA_W + 1;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W:0]   cnt_reg;
    logic [ADDR_W:0]   cnt_next;
    logic [ROM_LAT-1:0] pipe_valid_reg;
    logic [ROM_LAT-1:0] pipe_last_reg;

    logic              issue;
    logic              issue_last;
    logic              credit_ok;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_rd;
    logic [EW-1:0]     fifo_rd_data;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + CW'(pipe_valid_reg[i]);
        end
    end

    // The counter MSB means every address has been issued; the low bits may have wrapped to 0.
    assign credit_ok = !cnt_reg[ADDR_W] && !fifo_full &&
                       ((fifo_count + inflight) < CW'(FIFO_DEPTH));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        issue      = 1'b0;
        issue_last = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                if (credit_ok) begin
                    issue    = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                    if (&cnt_reg[ADDR_W-1:0]) begin
                        issue_last = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Empty FIFO with nothing in flight implies the last word was already accepted.
                if (inflight == '0 && fifo_empty) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Latency-matching pipe: each stage tags the ROM word that will appear ROM_LAT cycles later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid_reg <= '0;
            pipe_last_reg  <= '0;
        end else begin
            pipe_valid_reg[0] <= issue;
            pipe_last_reg[0]  <= issue_last;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_last_reg[i]  <= pipe_last_reg[i-1];
            end
        end
    end

    rom_stream_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (pipe_valid_reg[ROM_LAT-1]),
        .wr_data ({pipe_last_reg[ROM_LAT-1], rom_data}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign fifo_rd  = m_valid && m_ready;
    assign m_valid  = !fifo_empty;
    assign m_data   = fifo_empty ? '0 : fifo_rd_data[DATA_W-1:0];
    assign m_last   = !fifo_empty && fifo_rd_data[DATA_W];
    assign busy     = (state_reg != ST_IDLE);
    assign rom_addr = cnt_reg[ADDR_W-1:0];

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: cycle table for a free-running pass, a queue scoreboard
// with back-pressure, a mid-pass reset and a ROM_LAT=2 instance.
`timescale 1ns/1ps
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, m_ready;
    logic       busy, done, m_valid, m_last;
    logic [4:0] rom_addr;
    logic [7:0] rom_data, m_data;

    logic       start2, m_ready2;
    logic       busy2, done2, m_valid2, m_last2;
    logic [4:0] rom_addr2;
    logic [7:0] rom_data2, m_data2, rom2_s1;

    always #10 clk = ~clk;

    rom_stream_reader dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_data(rom_data), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    rom_stream_reader #(.ROM_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .m_data(m_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_last(m_last2)
    );

    // ROM models: contents are addr*3
    logic [7:0] rom_mem [32];
    initial for (int i = 0; i < 32; i++) rom_mem[i] = 8'(i * 3);
    always @(posedge clk) rom_data <= rom_mem[rom_addr];
    always @(posedge clk) begin
        rom2_s1   <= rom_mem[rom_addr2];
        rom_data2 <= rom2_s1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one pass is the ROM image in address order, last flag on the top address.
    typedef struct { logic last; logic [7:0] data; } beat_t;
    beat_t exp_q[$];

    task automatic expect_pass();
        beat_t b;
        for (int i = 0; i < 32; i++) begin
            b.last = (i == 31);
            b.data = 8'(i * 3);
            exp_q.push_back(b);
        end
    endtask

    // Stream monitor on the falling edge
    int         xfer_cnt = 0;
    int         outst = 0;
    logic [4:0] prev_addr = '0;
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = '0;

    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            outst     = 0;
            prev_v    = 1'b0;
            prev_addr = rom_addr;
        end else begin
            if (busy && rom_addr != prev_addr) outst++;
            prev_addr = rom_addr;
            chk("outstanding_le_4", outst <= 4, 1);
            if (prev_v && !prev_r) begin
                chk("stall_valid_held", m_valid, 1);
                chk("stall_data_held", m_data, prev_d);
            end
            if (m_valid && m_ready) begin
                chk("xfer_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    chk("xfer_data", m_data, b.data);
                    chk("xfer_last", m_last, b.last);
                end
                $display("xfer %0d: data=0x%02h last=%0b", xfer_cnt, m_data, m_last);
                xfer_cnt++;
                outst--;
            end
            prev_v = m_valid;
            prev_r = m_ready;
            prev_d = m_data;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_addr"}, rom_addr, 0);
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    typedef struct {
        logic       start;
        logic       ready;
        logic       busy;
        logic       done;
        logic       valid;
        logic       last;
        logic [7:0] data;
        logic [4:0] addr;
    } vec_t;
    vec_t tbl [38];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit seen_done;
        int base;
        int n;

        // Golden cycle table for ROM_LAT=1; cycle 0 is the cycle in which start is sampled.
        for (int c = 0; c < 38; c++) begin
            tbl[c].start = (c == 0 || c == 10 || c == 35 || c == 36);
            tbl[c].ready = 1'b1;
            tbl[c].busy  = (c >= 1 && c <= 35) || c == 37;
            tbl[c].done  = (c == 35);
            tbl[c].valid = (c >= 3 && c <= 34);
            tbl[c].last  = (c == 34);
            tbl[c].data  = tbl[c].valid ? 8'((c - 3) * 3) : 8'h00;
            tbl[c].addr  = (c >= 1 && c <= 32) ? 5'(c - 1) : 5'd0;
        end

        // Power-up reset with start held high
        reset = 1'b1; start = 1'b1; m_ready = 1'b1;
        start2 = 1'b0; m_ready2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset_outputs($sformatf("por%0d", i));
        end
        reset = 1'b0;
        expect_pass();

        // Free-running pass, start re-pulsed mid-pass, in the done cycle and after done
        for (int c = 0; c < 38; c++) begin
            start   = tbl[c].start;
            m_ready = tbl[c].ready;
            if (c == 36) expect_pass();
            chk($sformatf("vec%0d_busy", c), busy, tbl[c].busy);
            chk($sformatf("vec%0d_done", c), done, tbl[c].done);
            chk($sformatf("vec%0d_valid", c), m_valid, tbl[c].valid);
            chk($sformatf("vec%0d_last", c), m_last, tbl[c].last);
            chk($sformatf("vec%0d_addr", c), rom_addr, tbl[c].addr);
            if (tbl[c].valid) chk($sformatf("vec%0d_data", c), m_data, tbl[c].data);
            tick();
        end
        start = 1'b0;

        // Second pass: ready low for pass cycles 5-20, then random
        seen_done = 1'b0;
        for (int k = 2; k <= 800 && !seen_done; k++) begin
            m_ready = (k < 5) ? 1'b1 : (k <= 20) ? 1'b0 : 1'($urandom_range(0, 1));
            if (k == 20) begin
                chk("stall_addr", rom_addr, 6);
                chk("stall_valid", m_valid, 1);
                chk("stall_head", m_data, 6);
            end
            if (done) seen_done = 1'b1;
            tick();
        end
        chk("pass2_done_seen", seen_done, 1);
        chk("pass2_busy_low", busy, 0);
        chk("pass2_all_received", exp_q.size(), 0);

        // Reset in the middle of a pass
        m_ready = 1'b1;
        start = 1'b1;
        expect_pass();
        tick();
        start = 1'b0;
        base = xfer_cnt;
        n = 0;
        while (xfer_cnt < base + 10 && n < 200) begin
            tick();
            n++;
        end
        chk("midreset_10_xfers", xfer_cnt - base >= 10, 1);
        chk("midreset_pre_valid", m_valid, 1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        start = 1'b1;
        expect_pass();
        tick();
        start = 1'b0;
        chk("post_reset_addr", rom_addr, 0);
        chk("post_reset_busy", busy, 1);
        wait_done(200, ok);
        chk("post_reset_done_seen", ok, 1);
        tick();
        chk("post_reset_busy_low", busy, 0);
        chk("post_reset_all_received", exp_q.size(), 0);

        // ROM_LAT=2 instance with continuous ready
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c < 38; c++) begin
            chk($sformatf("lat2_c%0d_busy", c), busy2, (c <= 36));
            chk($sformatf("lat2_c%0d_valid", c), m_valid2, (c >= 4 && c <= 35));
            chk($sformatf("lat2_c%0d_last", c), m_last2, (c == 35));
            chk($sformatf("lat2_c%0d_done", c), done2, (c == 36));
            if (c >= 4 && c <= 35) chk($sformatf("lat2_c%0d_data", c), m_data2, 8'((c - 4) * 3));
            tick();
        end
        chk("lat2_busy_low", busy2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
